// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the codec audio receive path.
package audio_pkg;

    localparam int   AUDIO_WORD_BITS = 16;
    localparam logic CH_LEFT         = 1'b1;
    localparam logic CH_RIGHT        = 1'b0;

    typedef enum logic [1:0] {
        SYNC,
        SHIFT,
        WAIT
    } audio_rx_state_t;

    typedef struct packed {
        logic                       chan;
        logic [AUDIO_WORD_BITS-1:0] data;
    } audio_sample_t;

endpackage

// File: rtl/audio_rx_fifo.sv
// audio_rx_fifo: small synchronous FIFO with valid/ready pop, drop-on-full push and level count.
module audio_rx_fifo
    import audio_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = audio_sample_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_data,
    output logic                   drop,
    input  logic                   pop_ready,
    output T                       head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign valid   = (level != '0);
    assign do_pop  = valid && pop_ready;
    // A pop in the same cycle frees the slot the full-FIFO push needs.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: deserialises left-justified codec ADC words into a channel-tagged sample FIFO.
// Define AUDIO_RX_INSYNC_EN to add 2-flop synchronisers when the codec clocks are asynchronous.
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_BITS  = AUDIO_WORD_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          aud_bclk,
    input  logic                          aud_adclrck,
    input  logic                          aud_adcdat,
    output logic [WORD_BITS-1:0]          sample_data,
    output logic                          sample_chan,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err
);
    // state | meaning
    // SYNC  | out of reset, waiting for the first lrck edge
    // SHIFT | capturing slot bits MSB first
    // WAIT  | word pushed, ignoring the rest of the slot
    localparam int BW = $clog2(WORD_BITS) + 1;

    typedef struct packed {
        logic                 chan;
        logic [WORD_BITS-1:0] data;
    } word_t;

    logic bclk_s, lrck_s, dat_s;

`ifdef AUDIO_RX_INSYNC_EN
    logic [1:0] bclk_m, lrck_m, dat_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_m <= '0;
            lrck_m <= '0;
            dat_m  <= '0;
        end else begin
            bclk_m <= {bclk_m[0], aud_bclk};
            lrck_m <= {lrck_m[0], aud_adclrck};
            dat_m  <= {dat_m[0], aud_adcdat};
        end
    end

    assign bclk_s = bclk_m[1];
    assign lrck_s = lrck_m[1];
    assign dat_s  = dat_m[1];
`else
    assign bclk_s = aud_bclk;
    assign lrck_s = aud_adclrck;
    assign dat_s  = aud_adcdat;
`endif

    logic bclk_r, bclk_rr, lrck_r, lrck_rr, dat_r;
    logic bclk_rise, lrck_edge;

    // Both edge stages load the live level in reset so release never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_r  <= bclk_s;
            bclk_rr <= bclk_s;
            lrck_r  <= lrck_s;
            lrck_rr <= lrck_s;
        end else begin
            bclk_r  <= bclk_s;
            bclk_rr <= bclk_r;
            lrck_r  <= lrck_s;
            lrck_rr <= lrck_r;
        end
        dat_r <= dat_s;
    end

    assign bclk_rise = bclk_r & ~bclk_rr;
    assign lrck_edge = lrck_r ^ lrck_rr;

    audio_rx_state_t      state, state_nxt;
    logic [WORD_BITS-1:0] shreg, shreg_nxt, shifted;
    logic [BW-1:0]        bitcnt, bitcnt_nxt;
    logic                 chan, chan_nxt;
    logic                 push, frame_err_set, drop;
    word_t                push_word, head_word;

    assign shifted   = {shreg[WORD_BITS-2:0], dat_r};
    assign push_word = '{chan: chan, data: shifted};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SYNC;
            shreg     <= '0;
            bitcnt    <= '0;
            chan      <= CH_RIGHT;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bitcnt    <= bitcnt_nxt;
            chan      <= chan_nxt;
            frame_err <= frame_err | frame_err_set;
            overflow  <= overflow | drop;
        end
    end

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bitcnt_nxt    = bitcnt;
        chan_nxt      = chan;
        push          = 1'b0;
        frame_err_set = 1'b0;
        if (lrck_edge) begin
            // A coincident bit clock rise becomes the MSB of the new slot.
            state_nxt     = SHIFT;
            chan_nxt      = lrck_r;
            frame_err_set = (state == SHIFT);
            if (bclk_rise) begin
                shreg_nxt  = shifted;
                bitcnt_nxt = BW'(1);
            end else begin
                bitcnt_nxt = '0;
            end
        end else if (state == SHIFT && bclk_rise) begin
            shreg_nxt  = shifted;
            bitcnt_nxt = bitcnt + BW'(1);
            if (bitcnt == BW'(WORD_BITS - 1)) begin
                push      = 1'b1;
                state_nxt = WAIT;
            end
        end
    end

    audio_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (word_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .drop      (drop),
        .pop_ready (sample_ready),
        .head      (head_word),
        .valid     (sample_valid),
        .level     (fifo_level)
    );

    assign sample_data = head_word.data;
    assign sample_chan = head_word.chan;

endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx: directed and randomised slots against a slot-level capture/FIFO model.
module tb_audio_adc_rx;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        aud_bclk, aud_adclrck, aud_adcdat;
    logic [15:0] sample_data;
    logic        sample_chan, sample_valid, sample_ready;
    logic [2:0]  fifo_level;
    logic        overflow, frame_err;

    audio_adc_rx #(.FIFO_DEPTH(DEPTH), .WORD_BITS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .aud_bclk     (aud_bclk),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .sample_data  (sample_data),
        .sample_chan  (sample_chan),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] mq[$];
    logic [16:0] pend;
    int          push_cd = 0;
    bit          ovf_exp, ferr_exp, synced, in_short, rand_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check FIFO view at negedge, then advance the model at the posedge.
    task automatic tick();
        bit do_pop;
        @(negedge clk);
        chk("valid", 32'(sample_valid), 32'(mq.size() != 0));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        if (mq.size() != 0) begin
            chk("head_data", 32'(sample_data), 32'(mq[0][15:0]));
            chk("head_chan", 32'(sample_chan), 32'(mq[0][16]));
        end
        do_pop = sample_ready && (mq.size() != 0);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            push_cd = 0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (push_cd != 0) begin
                push_cd--;
                if (push_cd == 0) begin
                    if (mq.size() < DEPTH) mq.push_back(pend);
                    else ovf_exp = 1'b1;
                end
            end
        end
        #1;
        if (rand_ready) sample_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        ovf_exp = 1'b0; ferr_exp = 1'b0; synced = 1'b0; in_short = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        sample_ready = 1'b1;
        repeat (n) tick();
        sample_ready = 1'b0;
    endtask

    // One lrck slot of n bit clocks: word w MSB first, random filler after 16 bits.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int n,
                             input bit pop_at_push, input bit lat_chk);
        bit toggled, cap;
        toggled = (lr !== aud_adclrck);
        if (toggled) begin
            if (in_short) ferr_exp = 1'b1;
            synced = 1'b1;
        end
        cap      = synced && toggled && (n >= 16);
        in_short = synced && toggled && (n < 16);
        aud_adclrck = lr;
        for (int i = 0; i < n; i++) begin
            aud_bclk   = 1'b0;
            aud_adcdat = (i < 16) ? w[15 - i] : 1'($urandom_range(0, 1));
            tick(); tick();
            aud_bclk = 1'b1;
            if (i == 15 && cap) begin
                pend    = {lr, w};
                push_cd = 2;
            end
            tick();
            if (i == 15 && pop_at_push) sample_ready = 1'b1;
            if (i == 15 && lat_chk) chk("lat_1clk_valid", 32'(sample_valid), 32'd0);
            tick();
            if (i == 15 && pop_at_push) sample_ready = 1'b0;
            if (i == 15 && lat_chk) begin
                chk("lat_2clk_valid", 32'(sample_valid), 32'd1);
                chk("lat_2clk_data", 32'(sample_data), 32'(w));
                chk("lat_2clk_chan", 32'(sample_chan), 32'(lr));
            end
        end
        chk("frame_err", 32'(frame_err), 32'(ferr_exp));
        chk("overflow", 32'(overflow), 32'(ovf_exp));
    endtask

    initial begin
        logic [15:0] w0;
        reset = 1'b1; aud_bclk = 1'b0; aud_adclrck = 1'b0; aud_adcdat = 1'b0;
        sample_ready = 1'b0; rand_ready = 1'b0;
        @(posedge clk); #1;
        reset_dut();
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_chan", 32'(sample_chan), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);

        // Released mid-slot: the pre-edge word must be ignored.
        sample_ready = 1'b1;
        send_slot(1'b0, 16'hFFFF, 32, 1'b0, 1'b0);
        send_slot(1'b1, 16'h1234, 32, 1'b0, 1'b0);
        send_slot(1'b0, 16'hABCD, 32, 1'b0, 1'b0);

        send_slot(1'b1, 16'h8001, 32, 1'b0, 1'b1);
        sample_ready = 1'b0;

        rand_ready = 1'b1;
        for (int s = 0; s < 8; s++) send_slot(~aud_adclrck, 16'($urandom), 32, 1'b0, 1'b0);
        rand_ready = 1'b0;
        drain(8);

        sample_ready = 1'b0;
        w0 = 16'($urandom);
        send_slot(~aud_adclrck, w0, 32, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) send_slot(~aud_adclrck, 16'($urandom), 32, 1'b0, 1'b0);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(sample_data), 32'(w0));

        send_slot(~aud_adclrck, 16'h5AA5, 32, 1'b1, 1'b0);
        chk("fullpop_level", 32'(fifo_level), 32'd4);
        chk("fullpop_overflow", 32'(overflow), 32'd1);
        drain(10);

        send_slot(~aud_adclrck, 16'h0F0F, 10, 1'b0, 1'b0);
        send_slot(~aud_adclrck, 16'h7FFF, 32, 1'b0, 1'b0);
        chk("short_frame_err", 32'(frame_err), 32'd1);
        chk("short_next_data", 32'(sample_data), 32'h7FFF);
        drain(4);

        for (int s = 0; s < 3; s++) send_slot(~aud_adclrck, 16'($urandom), 32, 1'b0, 1'b0);
        send_slot(~aud_adclrck, 16'hFFFF, 8, 1'b0, 1'b0);
        reset = 1'b1;
        ovf_exp = 1'b0; ferr_exp = 1'b0; synced = 1'b0; in_short = 1'b0;
        tick();
        chk("rstmid_level", 32'(fifo_level), 32'd0);
        chk("rstmid_valid", 32'(sample_valid), 32'd0);
        tick();
        reset = 1'b0;
        send_slot(aud_adclrck, 16'h5555, 32, 1'b0, 1'b0);
        chk("rstmid_nocapture", 32'(fifo_level), 32'd0);
        send_slot(~aud_adclrck, 16'hC3C3, 32, 1'b0, 1'b0);
        chk("rstmid_resume_level", 32'(fifo_level), 32'd1);
        chk("rstmid_resume_data", 32'(sample_data), 32'hC3C3);
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_adc_rx.md
# audio_adc_rx

Receive path for the SSM2603 codec: deserialises left-justified 16-bit ADC samples from `AUD_ADCDAT` using the bit clock and LR clock already driven by the DAC-side codec block. Completed words are tagged by channel and queued in a small FIFO for the audio/game logic. All inputs are synchronous to the same master clock, so no clock-domain crossing is needed by default.

## Interface
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two, ≥2
- `WORD_BITS`, 16: bits captured per channel slot, MSB first
- `clk` input 1: master clock; the same clock that generates `AUD_BCLK` and `AUD_ADCLRCK`
- `reset` input 1: synchronous, active-high
- `aud_bclk` input 1: bit clock (period 4 clk)
- `aud_adclrck` input 1: ADC LR clock (period 256 clk); 1 = channel 1 (left), 0 = channel 0 (right)
- `aud_adcdat` input 1: serial ADC data; changes after `aud_bclk` falls
- `sample_data` output WORD_BITS: FIFO head sample, two's complement
- `sample_chan` output 1: channel of the head sample (lrck level during capture)
- `sample_valid` output 1: FIFO non-empty
- `sample_ready` input 1: consumer pops the head on `sample_valid && sample_ready`
- `fifo_level` output $clog2(FIFO_DEPTH)+1: current occupancy
- `overflow` output 1: sticky; a completed word was dropped
- `frame_err` output 1: sticky; an lrck edge arrived before WORD_BITS bits

## Operation
- Edge detect: register `aud_bclk` and `aud_adclrck` once. `bclk_rise` = cur & ~prev. `lrck_edge` = cur ^ prev.
- FSM states: SYNC, SHIFT, WAIT.
  - SYNC (reset state): ignore data. On `lrck_edge`, go to SHIFT and latch `chan` = new lrck level. Partial frames after reset are never captured.
  - SHIFT: on each `bclk_rise`, `shreg <= {shreg[WORD_BITS-2:0], aud_adcdat}` and `bitcnt++`. When `bitcnt` reaches WORD_BITS, push `{chan, shreg}` and go to WAIT.
  - WAIT: ignore bits 17..32 of the slot. On `lrck_edge`, go to SHIFT, clear `bitcnt`, latch the new `chan`.
- `lrck_edge` in SHIFT with `bitcnt` < WORD_BITS: no push; set `frame_err`; restart SHIFT for the new channel.
- `lrck_edge` and `bclk_rise` in the same cycle: the edge wins. The counter restarts at 0 and that bit is sampled as the new word's MSB.
- FIFO push when full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the word is dropped and `overflow` is set.
- Pop when empty: ignored.
- `overflow` and `frame_err` clear only on reset.
- `bitcnt` width is $clog2(WORD_BITS)+1. FIFO pointers wrap modulo FIFO_DEPTH. `fifo_level` is 0..FIFO_DEPTH.

## Timing
- Reset values:
  - Outputs: `sample_data`=0, `sample_chan`=0, `sample_valid`=0, `fifo_level`=0, `overflow`=0, `frame_err`=0.
  - Internal: FSM=SYNC, `shreg`=0, `bitcnt`=0, edge registers take the current input values.
- Latency: the last (LSB) `bclk_rise` is seen 1 clk after the pin rises. The push happens on that cycle's edge. `sample_valid` and `sample_data` update on the following clk, so the total is 2 clk from the pin rising to valid.
- Head data is registered and stable while `sample_valid && !sample_ready`.
- Reset mid-word: the partial word is discarded, the FIFO is emptied, and the FSM returns to SYNC.
- Throughput: 2 words per 256 clk. A consumer that pops within 128 clk never overflows.

## Configuration
- Macro: `AUDIO_RX_INSYNC_EN`.
- Defined: insert 2-flop synchronisers on `aud_bclk`, `aud_adclrck` and `aud_adcdat` ahead of edge detection. Use this when the codec clocks are external or asynchronous. Every latency above grows by 2 clk. Reset values of the synchroniser flops are 0.
- Undefined: inputs feed the edge-detect registers directly (same-clock operation).

## Structure
- Shared package `audio_pkg`:
  - `AUDIO_WORD_BITS` = 16
  - `CH_LEFT` = 1'b1, `CH_RIGHT` = 1'b0
  - typedef enum `audio_rx_state_t` {SYNC, SHIFT, WAIT}
  - packed struct `audio_sample_t` {chan, data}
- Sub-module `audio_rx_fifo`: synchronous FIFO with valid/ready pop, push/full, level and registered head. It is parameterised by depth and the element type.

## Test plan
- Reset sync: release reset mid-slot and send 16'hFFFF before the first lrck edge. Then send frame L=16'h1234, R=16'hABCD. Expect exactly two outputs: (1,16'h1234) then (0,16'hABCD). `frame_err`=0.
- Latency: send L=16'h8001 with `sample_ready`=1. `sample_valid` rises exactly 2 clk after the 16th `aud_bclk` rise, or 4 clk with `AUDIO_RX_INSYNC_EN`.
- Overflow: with FIFO_DEPTH=4 and `sample_ready`=0, send 3 stereo frames. Expect `fifo_level`=4 and `overflow`=1. The head stays equal to the first word.
- Full plus pop: hold the FIFO full and assert `sample_ready` on the push cycle. The new word is accepted, `fifo_level` stays 4, and `overflow` is unchanged.
- Short frame: toggle lrck after 10 bits. Expect `frame_err`=1 and no push. The next full slot 16'h7FFF is captured correctly.
- Reset mid-operation: assert reset with 3 words queued and 8 bits shifted. The next cycle shows `fifo_level`=0 and `sample_valid`=0. Capture resumes only after the next lrck edge.
